// File: rtl/i2c_host_arbiter.sv
// Round-robin arbiter that shares one I2C master host port among N_REQ clients,
// launching one transaction at a time and returning read data and status.
module i2c_host_arbiter #(
  parameter int N_REQ         = 4,
  parameter int SEL_CYCLES    = 4,
  parameter int START_TIMEOUT = 1024,
  parameter int XFER_TIMEOUT  = 1048575
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_REQ-1:0]    req_valid_i,
  input  logic [8*N_REQ-1:0]  req_addr_i,
  input  logic [32*N_REQ-1:0] req_data_i,
  input  logic [4*N_REQ-1:0]  req_cmd_i,
  output logic [N_REQ-1:0]    req_ready_o,
  output logic [N_REQ-1:0]    rsp_valid_o,
  output logic [31:0]         rsp_data_o,
  output logic                rsp_error_o,
  output logic                rsp_timeout_o,
  output logic [7:0]          host_addr_o,
  output logic [31:0]         host_data_o,
  output logic [3:0]          host_cmd_o,
  output logic                host_sel_o,
  input  logic [31:0]         host_data_i,
  input  logic                host_busy_i,
  input  logic                host_error_i,
  output logic [2:0]          grant_id_o,
  output logic                active_o
);
  localparam int SW = (SEL_CYCLES > 1) ? $clog2(SEL_CYCLES) : 1;
  localparam logic [SW-1:0] L_SEL_LAST   = SW'(SEL_CYCLES - 1);
  localparam logic [19:0]   L_START_LAST = 20'(START_TIMEOUT - 1);
  localparam logic [19:0]   L_XFER_LAST  = 20'(XFER_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_RESP} state_t;

  state_t        r_state, w_state_next;
  logic          r_busy_m, r_busy_s, r_err_m, r_err_s;
  logic [2:0]    r_ptr, r_gid;
  logic [19:0]   r_cnt;
  logic [SW-1:0] r_sel_cnt;
  logic [7:0]    r_host_addr;
  logic [31:0]   r_host_data, r_rsp_data;
  logic [3:0]    r_host_cmd;
  logic          r_rsp_err, r_rsp_to;

  logic          w_hi_found, w_lo_found, w_found, w_grant, w_cmd_ok;
  logic [2:0]    w_hi, w_lo, w_win;
  logic [7:0]    w_sel_addr;
  logic [31:0]   w_sel_data;
  logic [3:0]    w_sel_cmd;
  logic          w_start_to, w_xfer_to;

  // Synchronizers are left out of reset so busy_s stays truthful across a reset.
  always_ff @(posedge clk_i) begin
    r_busy_m <= host_busy_i;
    r_busy_s <= r_busy_m;
    r_err_m  <= host_error_i;
    r_err_s  <= r_err_m;
  end

  // Rotating priority: first valid above the pointer wins, else lowest valid index.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi       = '0;
    w_lo       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_hi_found && req_valid_i[i] && (3'(i) > r_ptr)) begin
        w_hi_found = 1'b1;
        w_hi       = 3'(i);
      end
      if (!w_lo_found && req_valid_i[i]) begin
        w_lo_found = 1'b1;
        w_lo       = 3'(i);
      end
    end
    w_found    = w_hi_found || w_lo_found;
    w_win      = w_hi_found ? w_hi : w_lo;
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_cmd  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == 3'(i)) begin
        w_sel_addr = req_addr_i[8*i +: 8];
        w_sel_data = req_data_i[32*i +: 32];
        w_sel_cmd  = req_cmd_i[4*i +: 4];
      end
    end
  end

  assign w_grant    = !rst_i && (r_state == S_IDLE) && !r_busy_s && w_found;
  assign w_cmd_ok   = !w_sel_cmd[3];
  assign w_start_to = (r_cnt >= L_START_LAST);
  assign w_xfer_to  = (r_cnt >= L_XFER_LAST);

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_strobe
    assign req_ready_o[gi] = w_grant && (w_win == 3'(gi));
    assign rsp_valid_o[gi] = (r_state == S_RESP) && (r_gid == 3'(gi));
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_grant) w_state_next = w_cmd_ok ? S_LAUNCH : S_RESP;
      S_LAUNCH:    if (r_sel_cnt == L_SEL_LAST) w_state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (r_busy_s)        w_state_next = S_WAIT_DONE;
        else if (w_start_to) w_state_next = S_RESP;
      end
      S_WAIT_DONE: if (!r_busy_s || w_xfer_to) w_state_next = S_RESP;
      S_RESP:      w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_ptr       <= 3'(N_REQ - 1);
      r_gid       <= '0;
      r_cnt       <= '0;
      r_sel_cnt   <= '0;
      r_host_addr <= '0;
      r_host_data <= '0;
      r_host_cmd  <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_to    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: if (w_grant) begin
          r_host_addr <= w_sel_addr;
          r_host_data <= w_sel_data;
          r_host_cmd  <= w_sel_cmd;
          r_gid       <= w_win;
          r_cnt       <= '0;
          r_sel_cnt   <= '0;
          if (!w_cmd_ok) begin
            r_rsp_err <= 1'b1;
            r_rsp_to  <= 1'b0;
          end
        end
        S_LAUNCH: begin
          r_sel_cnt <= r_sel_cnt + SW'(1);
          r_cnt     <= r_cnt + 20'd1;
        end
        S_WAIT_BUSY: begin
          if (r_busy_s) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 20'd1;
            if (w_start_to) begin
              r_rsp_err <= 1'b1;
              r_rsp_to  <= 1'b1;
            end
          end
        end
        S_WAIT_DONE: begin
          if (!r_busy_s) begin
            r_rsp_data <= host_data_i;
            r_rsp_err  <= r_err_s;
            r_rsp_to   <= 1'b0;
          end else if (w_xfer_to) begin
            r_rsp_err <= 1'b1;
            r_rsp_to  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
        end
        S_RESP:  r_ptr <= r_gid;
        default: ;
      endcase
    end
  end

  assign host_sel_o    = !rst_i && (r_state == S_LAUNCH);
  assign active_o      = !rst_i && ((r_state != S_IDLE) || w_grant);
  assign host_addr_o   = r_host_addr;
  assign host_data_o   = r_host_data;
  assign host_cmd_o    = r_host_cmd;
  assign grant_id_o    = r_gid;
  assign rsp_data_o    = r_rsp_data;
  assign rsp_error_o   = r_rsp_err;
  assign rsp_timeout_o = r_rsp_to;
endmodule

// File: tb/tb_i2c_host_arbiter.sv
// Directed bench for i2c_host_arbiter: a hand-driven master model on the host
// port and hand-computed expectations for grants, strobes, status and timeouts.
module tb_i2c_host_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid_i = '0;
  logic [31:0]  req_addr_i = '0;
  logic [127:0] req_data_i = '0;
  logic [15:0]  req_cmd_i = '0;
  logic [3:0]   req_ready_o, rsp_valid_o;
  logic [31:0]  rsp_data_o, host_data_o;
  logic         rsp_error_o, rsp_timeout_o, host_sel_o, active_o;
  logic [7:0]   host_addr_o;
  logic [3:0]   host_cmd_o;
  logic [31:0]  host_data_i = '0;
  logic         host_busy_i = 1'b0, host_error_i = 1'b0;
  logic [2:0]   grant_id_o;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  i2c_host_arbiter #(
    .N_REQ(4), .SEL_CYCLES(4), .START_TIMEOUT(16), .XFER_TIMEOUT(32)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_cmd_i(req_cmd_i),
    .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
    .rsp_data_o(rsp_data_o), .rsp_error_o(rsp_error_o),
    .rsp_timeout_o(rsp_timeout_o),
    .host_addr_o(host_addr_o), .host_data_o(host_data_o),
    .host_cmd_o(host_cmd_o), .host_sel_o(host_sel_o),
    .host_data_i(host_data_i), .host_busy_i(host_busy_i),
    .host_error_i(host_error_i),
    .grant_id_o(grant_id_o), .active_o(active_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic set_req(input int idx, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] c);
    for (int i = 0; i < 4; i++) begin
      if (i == idx) begin
        req_addr_i[8*i +: 8]  = a;
        req_data_i[32*i +: 32] = d;
        req_cmd_i[4*i +: 4]   = c;
      end
    end
  endtask

  task automatic wait_rsp(output logic [3:0] v, output int lat);
    v = '0;
    lat = -1;
    for (int i = 0; i < 80; i++) begin
      tick();
      samp();
      if (rsp_valid_o != '0) begin
        v = rsp_valid_o;
        lat = i + 1;
        break;
      end
    end
  endtask

  task automatic wait_ready(output logic [3:0] v, output int lat);
    v = '0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      samp();
      if (req_ready_o != '0) begin
        v = req_ready_o;
        lat = i + 1;
        break;
      end
    end
  endtask

  // Runs the master side of a launched transaction, starting from the grant cycle.
  task automatic serve(input logic [3:0] keep, input logic [31:0] rd, input logic ne,
                       output int nsel, output logic [3:0] v);
    int lat;
    tick();
    req_valid_i = keep;
    samp();
    nsel = 0;
    for (int i = 0; i < 40 && host_sel_o; i++) begin
      nsel++;
      tick();
      samp();
    end
    host_busy_i = 1'b1;
    repeat (6) tick();
    host_data_i  = rd;
    host_error_i = ne;
    host_busy_i  = 1'b0;
    wait_rsp(v, lat);
    host_error_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord [5] = '{0, 1, 2, 3, 0};
    int nsel, lat;
    logic [3:0] v, acc;

    for (int i = 0; i < 4; i++) set_req(i, 8'(8'h10 + i), 32'(i), 4'h1);
    req_valid_i = 4'hF;
    repeat (3) tick();
    samp();
    chk("rst_ready", 32'(req_ready_o), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    chk("rst_active", 32'(active_o), 32'h0);
    chk("rst_sel", 32'(host_sel_o), 32'h0);
    chk("rst_grant_id", 32'(grant_id_o), 32'h0);
    chk("rst_err_to", {30'h0, rsp_error_o, rsp_timeout_o}, 32'h0);
    chk("rst_rsp_data", rsp_data_o, 32'h0);
    chk("rst_host_addr", 32'(host_addr_o), 32'h0);

    // Contention: all four requesters held valid out of reset.
    tick();
    rst = 1'b0;
    samp();
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        v = req_ready_o;
        lat = 1;
      end else begin
        wait_ready(v, lat);
      end
      $display("contention grant %0d: ready=%b lat=%0d", k, v, lat);
      chk("cont_ready", 32'(v), 32'(1) << ord[k]);
      chk("cont_lat", 32'(lat), 32'd1);
      serve(4'hF, 32'h0, 1'b0, nsel, v);
      chk("cont_sel_len", 32'(nsel), 32'd4);
      chk("cont_rsp", 32'(v), 32'(1) << ord[k]);
      chk("cont_no_ready_in_resp", 32'(req_ready_o), 32'h0);
      chk("cont_gid", 32'(grant_id_o), 32'(ord[k]));
    end
    tick();
    req_valid_i = '0;
    samp();
    chk("idle_ready", 32'(req_ready_o), 32'h0);
    chk("idle_active", 32'(active_o), 32'h0);

    // Single write on req0.
    tick();
    set_req(0, 8'h50, 32'h0000_BEEF, 4'h1);
    req_valid_i = 4'b0001;
    samp();
    chk("wr_ready", 32'(req_ready_o), 32'h1);
    chk("wr_active", 32'(active_o), 32'h1);
    serve(4'b0000, 32'h0000_1234, 1'b0, nsel, v);
    $display("write: sel_len=%0d rsp=%b err=%b", nsel, v, rsp_error_o);
    chk("wr_sel_len", 32'(nsel), 32'd4);
    chk("wr_rsp", 32'(v), 32'h1);
    chk("wr_err", 32'(rsp_error_o), 32'h0);
    chk("wr_to", 32'(rsp_timeout_o), 32'h0);
    chk("wr_host_addr", 32'(host_addr_o), 32'h50);
    chk("wr_host_data", host_data_o, 32'h0000_BEEF);
    chk("wr_host_cmd", 32'(host_cmd_o), 32'h1);
    tick();
    samp();
    chk("wr_rsp_pulse", 32'(rsp_valid_o), 32'h0);
    chk("wr_active_drop", 32'(active_o), 32'h0);

    // Single read on req2.
    tick();
    set_req(2, 8'h51, 32'h0, 4'h7);
    req_valid_i = 4'b0100;
    samp();
    chk("rd_ready", 32'(req_ready_o), 32'h4);
    serve(4'b0000, 32'hDEAD_BEEF, 1'b0, nsel, v);
    $display("read: rsp=%b data=%h err=%b", v, rsp_data_o, rsp_error_o);
    chk("rd_rsp", 32'(v), 32'h4);
    chk("rd_data", rsp_data_o, 32'hDEAD_BEEF);
    chk("rd_err", 32'(rsp_error_o), 32'h0);
    chk("rd_gid", 32'(grant_id_o), 32'h2);

    // NACK from absent slave on req3, then a normal request on req1.
    tick();
    set_req(3, 8'h3A, 32'h11, 4'h0);
    req_valid_i = 4'b1000;
    samp();
    chk("nack_ready", 32'(req_ready_o), 32'h8);
    serve(4'b0000, 32'h0, 1'b1, nsel, v);
    $display("nack: rsp=%b err=%b to=%b", v, rsp_error_o, rsp_timeout_o);
    chk("nack_rsp", 32'(v), 32'h8);
    chk("nack_err", 32'(rsp_error_o), 32'h1);
    chk("nack_to", 32'(rsp_timeout_o), 32'h0);
    tick();
    set_req(1, 8'h50, 32'h0000_CAFE, 4'h1);
    req_valid_i = 4'b0010;
    samp();
    chk("after_nack_ready", 32'(req_ready_o), 32'h2);
    serve(4'b0000, 32'h55AA_55AA, 1'b0, nsel, v);
    $display("after nack: rsp=%b err=%b data=%h", v, rsp_error_o, rsp_data_o);
    chk("after_nack_rsp", 32'(v), 32'h2);
    chk("after_nack_err", 32'(rsp_error_o), 32'h0);
    chk("after_nack_data", rsp_data_o, 32'h55AA_55AA);

    // Invalid command on req1: immediate response, no launch.
    tick();
    set_req(1, 8'h50, 32'h0, 4'hC);
    req_valid_i = 4'b0010;
    samp();
    chk("inv_ready", 32'(req_ready_o), 32'h2);
    chk("inv_sel_grant", 32'(host_sel_o), 32'h0);
    tick();
    req_valid_i = '0;
    samp();
    $display("invalid: rsp=%b sel=%b err=%b to=%b", rsp_valid_o, host_sel_o, rsp_error_o, rsp_timeout_o);
    chk("inv_rsp", 32'(rsp_valid_o), 32'h2);
    chk("inv_sel_resp", 32'(host_sel_o), 32'h0);
    chk("inv_err", 32'(rsp_error_o), 32'h1);
    chk("inv_to", 32'(rsp_timeout_o), 32'h0);
    chk("inv_data_kept", rsp_data_o, 32'h55AA_55AA);
    tick();
    samp();
    chk("inv_rsp_pulse", 32'(rsp_valid_o), 32'h0);

    // Start timeout: master never raises busy.
    tick();
    set_req(0, 8'h50, 32'h1, 4'h1);
    req_valid_i = 4'b0001;
    samp();
    chk("sto_ready", 32'(req_ready_o), 32'h1);
    tick();
    req_valid_i = '0;
    samp();
    wait_rsp(v, lat);
    $display("start timeout: rsp=%b lat=%0d err=%b to=%b", v, lat, rsp_error_o, rsp_timeout_o);
    chk("sto_rsp", 32'(v), 32'h1);
    chk("sto_lat", 32'(lat), 32'd16);
    chk("sto_err", 32'(rsp_error_o), 32'h1);
    chk("sto_to", 32'(rsp_timeout_o), 32'h1);

    // Transfer timeout: busy stuck high, then no grant until busy falls.
    tick();
    set_req(2, 8'h51, 32'h0, 4'h7);
    req_valid_i = 4'b0100;
    samp();
    chk("xto_ready", 32'(req_ready_o), 32'h4);
    tick();
    req_valid_i = '0;
    samp();
    host_busy_i = 1'b1;
    wait_rsp(v, lat);
    $display("xfer timeout: rsp=%b lat=%0d err=%b to=%b data=%h", v, lat, rsp_error_o, rsp_timeout_o, rsp_data_o);
    chk("xto_rsp", 32'(v), 32'h4);
    chk("xto_lat", 32'(lat), 32'd37);
    chk("xto_err", 32'(rsp_error_o), 32'h1);
    chk("xto_to", 32'(rsp_timeout_o), 32'h1);
    chk("xto_data_kept", rsp_data_o, 32'h55AA_55AA);
    tick();
    set_req(0, 8'h50, 32'h2, 4'h1);
    req_valid_i = 4'b0001;
    samp();
    acc = req_ready_o;
    for (int i = 0; i < 4; i++) begin
      tick();
      samp();
      acc = acc | req_ready_o;
    end
    chk("xto_hold_while_busy", 32'(acc), 32'h0);
    host_busy_i = 1'b0;
    wait_ready(v, lat);
    chk("xto_regrant", 32'(v), 32'h1);
    chk("xto_regrant_lat", 32'(lat), 32'd2);
    serve(4'b0000, 32'h0BAD_F00D, 1'b0, nsel, v);
    chk("xto_next_rsp", 32'(v), 32'h1);
    chk("xto_next_flags", {30'h0, rsp_error_o, rsp_timeout_o}, 32'h0);
    chk("xto_next_data", rsp_data_o, 32'h0BAD_F00D);

    // Reset while in WAIT_DONE with the master still busy.
    tick();
    set_req(3, 8'h22, 32'h3, 4'h1);
    req_valid_i = 4'b1000;
    samp();
    chk("mrst_ready", 32'(req_ready_o), 32'h8);
    tick();
    req_valid_i = '0;
    samp();
    host_busy_i = 1'b1;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    samp();
    $display("mid reset: active=%b sel=%b gid=%0d data=%h", active_o, host_sel_o, grant_id_o, rsp_data_o);
    chk("mrst_active", 32'(active_o), 32'h0);
    chk("mrst_sel", 32'(host_sel_o), 32'h0);
    chk("mrst_gid", 32'(grant_id_o), 32'h0);
    chk("mrst_host_addr", 32'(host_addr_o), 32'h0);
    chk("mrst_rsp_data", rsp_data_o, 32'h0);
    tick();
    rst = 1'b0;
    set_req(0, 8'h50, 32'h4, 4'h1);
    req_valid_i = 4'b0001;
    samp();
    acc = req_ready_o;
    for (int i = 0; i < 3; i++) begin
      tick();
      samp();
      acc = acc | req_ready_o;
    end
    chk("mrst_hold_while_busy", 32'(acc), 32'h0);
    host_busy_i = 1'b0;
    wait_ready(v, lat);
    chk("mrst_regrant", 32'(v), 32'h1);
    chk("mrst_regrant_lat", 32'(lat), 32'd2);
    serve(4'b0000, 32'h1357_9BDF, 1'b0, nsel, v);
    chk("mrst_next_rsp", 32'(v), 32'h1);
    chk("mrst_next_data", rsp_data_o, 32'h1357_9BDF);
    tick();
    samp();
    chk("final_active", 32'(active_o), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
